// File: rtl/half_adder_0_pkg.sv
// Shared constants for the half_adder_0 slice: encodings of the available
// cell realisations and a legality check used at elaboration.
package half_adder_0_pkg;

    localparam int STYLE_GATE     = 0;
    localparam int STYLE_DATAFLOW = 1;
    localparam int STYLE_BEHAV    = 2;

    function automatic bit styleIsLegal(input int style);
        return (style >= STYLE_GATE) && (style <= STYLE_BEHAV);
    endfunction

endpackage

// File: rtl/half_adder_0_cell.sv
// One-bit half adder; STYLE picks gate, dataflow or behavioural realisation,
// all of which produce identical sum/carry and pass X straight through.
module half_adder_cell
    import half_adder_0_pkg::*;
#(
    parameter int STYLE = STYLE_GATE
) (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    generate
        if (!styleIsLegal(STYLE)) begin : g_illegal
            $error("half_adder_cell: unsupported STYLE %0d", STYLE);
        end

        if (STYLE == STYLE_GATE) begin : g_gate
            wire w_sum;
            wire w_carry;
            xor u_xor (w_sum, i_a, i_b);
            and u_and (w_carry, i_a, i_b);
            assign o_sum   = w_sum;
            assign o_carry = w_carry;
        end else if (STYLE == STYLE_DATAFLOW) begin : g_dataflow
            assign o_sum   = i_a ^ i_b;
            assign o_carry = i_a & i_b;
        end else begin : g_behav
            always_comb begin
                o_sum   = i_a ^ i_b;
                o_carry = i_a & i_b;
            end
        end
    endgenerate

endmodule

// File: rtl/half_adder_0.sv
// Bit-parallel half adder: zero-latency combinational result plus a registered
// copy and a saturating count of captures that produced any carry.
module half_adder_0
    import half_adder_0_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int STYLE = STYLE_GATE,
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             en_in,
    output logic [WIDTH-1:0] sum_out,
    output logic [WIDTH-1:0] carry_out,
    output logic [WIDTH-1:0] sum_q_out,
    output logic [WIDTH-1:0] carry_q_out,
    output logic             valid_q_out,
    output logic [CNT_W-1:0] carry_cnt_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic             w_carryEvent;

    logic [WIDTH-1:0] r_sumQ;
    logic [WIDTH-1:0] r_carryQ;
    logic             r_validQ;
    logic [CNT_W-1:0] r_carryCnt;

    generate
        if (WIDTH < 1 || CNT_W < 1) begin : g_badParam
            $error("half_adder_0: WIDTH and CNT_W must be at least 1");
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            half_adder_cell #(
                .STYLE   (STYLE)
            ) u_cell (
                .i_a     (a_in[i]),
                .i_b     (b_in[i]),
                .o_sum   (w_sum[i]),
                .o_carry (w_carry[i])
            );
        end
    endgenerate

    assign w_carryEvent = |w_carry;

    // Counter holds at all-ones once reached; result registers still follow en_in.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sumQ     <= '0;
            r_carryQ   <= '0;
            r_validQ   <= 1'b0;
            r_carryCnt <= '0;
        end else if (en_in) begin
            r_sumQ   <= w_sum;
            r_carryQ <= w_carry;
            r_validQ <= 1'b1;
            if (w_carryEvent && (r_carryCnt != CNT_MAX)) begin
                r_carryCnt <= r_carryCnt + CNT_ONE;
            end
        end
    end

    assign sum_out       = w_sum;
    assign carry_out     = w_carry;
    assign sum_q_out     = r_sumQ;
    assign carry_q_out   = r_carryQ;
    assign valid_q_out   = r_validQ;
    assign carry_cnt_out = r_carryCnt;

endmodule

// File: tb/tb_half_adder_0.sv
// Scoreboard bench for half_adder_0: five instances (each STYLE at WIDTH=1, an
// 8-bit one, a CNT_W=2 one) checked against an arithmetic reference model.
module tb_half_adder_0;

    localparam int NDUT = 5;

    typedef struct {
        string      tag;
        int         dut;
        logic [7:0] s;
        logic [7:0] c;
        logic [7:0] sq;
        logic [7:0] cq;
        logic       v;
        logic [15:0] n;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [0:0] a1 = '0, b1 = '0;
    logic       en1 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       en8 = 1'b0;
    logic [0:0] ac = '0, bc = '0;
    logic       enc = 1'b0;

    logic [0:0]  s1[3], c1[3], sq1[3], cq1[3];
    logic        v1[3];
    logic [15:0] n1[3];
    logic [7:0]  s8, c8, sq8, cq8;
    logic        v8;
    logic [15:0] n8;
    logic [0:0]  sc, cc, sqc, cqc;
    logic        vc;
    logic [1:0]  nc;

    exp_t expQ[$];
    event sampleEv;
    int   tests = 0;
    int   failures = 0;
    int   ttScore[3] = '{0, 0, 0};
    bit   done = 1'b0;

    int         mWidth[NDUT]  = '{1, 1, 1, 8, 1};
    int         mCntMax[NDUT] = '{65535, 65535, 65535, 65535, 3};
    logic [7:0] mSumQ[NDUT];
    logic [7:0] mCarryQ[NDUT];
    logic       mValid[NDUT];
    int         mCnt[NDUT];

    generate
        for (genvar g = 0; g < 3; g++) begin : g_style
            half_adder_0 #(.WIDTH(1), .STYLE(g), .CNT_W(16)) dut (
                .clk_in        (clk),
                .rst_n_in      (rst_n),
                .a_in          (a1),
                .b_in          (b1),
                .en_in         (en1),
                .sum_out       (s1[g]),
                .carry_out     (c1[g]),
                .sum_q_out     (sq1[g]),
                .carry_q_out   (cq1[g]),
                .valid_q_out   (v1[g]),
                .carry_cnt_out (n1[g])
            );
        end
    endgenerate

    half_adder_0 #(.WIDTH(8), .STYLE(1), .CNT_W(16)) dutWide (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .a_in          (a8),
        .b_in          (b8),
        .en_in         (en8),
        .sum_out       (s8),
        .carry_out     (c8),
        .sum_q_out     (sq8),
        .carry_q_out   (cq8),
        .valid_q_out   (v8),
        .carry_cnt_out (n8)
    );

    half_adder_0 #(.WIDTH(1), .STYLE(2), .CNT_W(2)) dutCnt (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .a_in          (ac),
        .b_in          (bc),
        .en_in         (enc),
        .sum_out       (sc),
        .carry_out     (cc),
        .sum_q_out     (sqc),
        .carry_q_out   (cqc),
        .valid_q_out   (vc),
        .carry_cnt_out (nc)
    );

    always #5 clk = ~clk;

    function automatic void getInputs(input int d, output logic [7:0] a, output logic [7:0] b,
                                      output logic en);
        case (d)
            0, 1, 2: begin a = {7'b0, a1}; b = {7'b0, b1}; en = en1; end
            3:       begin a = a8;         b = b8;         en = en8; end
            default: begin a = {7'b0, ac}; b = {7'b0, bc}; en = enc; end
        endcase
    endfunction

    function automatic void getActual(input int d, output exp_t act);
        act.tag = "";
        act.dut = d;
        case (d)
            0, 1, 2: begin
                act.s = {7'b0, s1[d]};  act.c = {7'b0, c1[d]};
                act.sq = {7'b0, sq1[d]}; act.cq = {7'b0, cq1[d]};
                act.v = v1[d];          act.n = n1[d];
            end
            3: begin
                act.s = s8; act.c = c8; act.sq = sq8; act.cq = cq8; act.v = v8; act.n = n8;
            end
            default: begin
                act.s = {7'b0, sc};  act.c = {7'b0, cc};
                act.sq = {7'b0, sqc}; act.cq = {7'b0, cqc};
                act.v = vc;          act.n = {14'b0, nc};
            end
        endcase
    endfunction

    // Reference: each bit position is a 1-bit addition; sum is the low digit, carry the high.
    function automatic void refAdd(input int w, input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] s, output logic [7:0] c);
        s = '0;
        c = '0;
        for (int i = 0; i < w; i++) begin
            int t;
            t = int'(a[i]) + int'(b[i]);
            s[i] = ((t % 2) == 1);
            c[i] = (t >= 2);
        end
    endfunction

    function automatic void modelReset();
        for (int d = 0; d < NDUT; d++) begin
            mSumQ[d] = '0; mCarryQ[d] = '0; mValid[d] = 1'b0; mCnt[d] = 0;
        end
    endfunction

    function automatic void modelEdge();
        logic [7:0] a, b, s, c;
        logic       en;
        if (!rst_n) return;
        for (int d = 0; d < NDUT; d++) begin
            getInputs(d, a, b, en);
            if (en) begin
                refAdd(mWidth[d], a, b, s, c);
                mSumQ[d] = s;
                mCarryQ[d] = c;
                mValid[d] = 1'b1;
                if (c != 0) mCnt[d] = (mCnt[d] < mCntMax[d]) ? mCnt[d] + 1 : mCntMax[d];
            end
        end
    endfunction

    // Pushes the expected view of every instance, then lets the monitor sample 1 ns later.
    task automatic applyStimulus(input string tag);
        logic [7:0] a, b, s, c;
        logic       en;
        for (int d = 0; d < NDUT; d++) begin
            exp_t e;
            getInputs(d, a, b, en);
            refAdd(mWidth[d], a, b, s, c);
            e.tag = tag; e.dut = d; e.s = s; e.c = c;
            e.sq = mSumQ[d]; e.cq = mCarryQ[d]; e.v = mValid[d]; e.n = 16'(mCnt[d]);
            expQ.push_back(e);
        end
        #1;
        -> sampleEv;
        #1;
    endtask

    task automatic clockEdge(input string tag);
        @(posedge clk);
        modelEdge();
        applyStimulus(tag);
    endtask

    task automatic checkOutput(input exp_t e);
        exp_t act;
        getActual(e.dut, act);
        tests++;
        if (act.s !== e.s || act.c !== e.c || act.sq !== e.sq || act.cq !== e.cq ||
            act.v !== e.v || act.n !== e.n) begin
            failures++;
            $display("[TB] FAIL %s dut%0d: got sum=%h carry=%h sumQ=%h carryQ=%h valid=%b cnt=%0d, want sum=%h carry=%h sumQ=%h carryQ=%h valid=%b cnt=%0d",
                     e.tag, e.dut, act.s, act.c, act.sq, act.cq, act.v, act.n,
                     e.s, e.c, e.sq, e.cq, e.v, e.n);
        end else if (e.tag == "tt" && e.dut < 3) begin
            ttScore[e.dut]++;
        end
    endtask

    initial begin
        forever begin
            @(sampleEv);
            while (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        #1000;
        if (!done) begin
            failures++;
            $display("[TB] FAIL watchdog: checks incomplete at %0t, required completion before 1000 ns", $time);
            $display("[TB] %0d tests run, %0d failed", tests, failures);
            $finish;
        end
    end

    initial begin
        rst_n = 1'b0;
        modelReset();
        a8 = 8'hA5; b8 = 8'h0F;
        applyStimulus("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            {a1, b1} = 2'(i);
            applyStimulus("tt");
            #3;
        end

        @(posedge clk);
        #2;
        a8 = 8'hF0; b8 = 8'h3C; en8 = 1'b1;
        applyStimulus("wide comb");
        clockEdge("wide reg");
        en8 = 1'b0;

        ac = 1'b1; bc = 1'b1; enc = 1'b1;
        for (int i = 0; i < 5; i++) clockEdge("cnt sat");
        bc = 1'b0;
        clockEdge("cnt no carry");
        bc = 1'b1;
        clockEdge("cnt sat update");
        enc = 1'b0;

        for (int i = 0; i < 3; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); ac = 1'($urandom); a1 = 1'($urandom);
            applyStimulus("hold comb");
            clockEdge("hold reg");
        end

        rst_n = 1'b0;
        modelReset();
        applyStimulus("reset pulse");
        rst_n = 1'b1;
        a8 = 8'hFF; b8 = 8'h01; en8 = 1'b1; ac = 1'b1; bc = 1'b1; enc = 1'b1;
        applyStimulus("post reset comb");
        clockEdge("post reset capture");

        for (int i = 0; i < 12; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); en1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); en8 = 1'($urandom);
            ac = 1'($urandom); bc = 1'($urandom); enc = 1'($urandom);
            applyStimulus("rand comb");
            clockEdge("rand reg");
        end
        en1 = 1'b0; en8 = 1'b0; enc = 1'b0;

        done = 1'b1;
        for (int d = 0; d < 3; d++) begin
            $display("[TB] truth table score style %0d: %0d of 4", d, ttScore[d]);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
